// File: rtl/regfile_monitor.sv
// Shadow register-file monitor: mirrors regfile writes, checks two read ports, then dumps contents.
// Optional REGMON_BYPASS_EN: a read of the register being written in the same cycle sees wr_data.
module regfile_monitor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MAX_CYCLES = 300,
  parameter int unsigned HEARTBEAT  = 100,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  chk_en,
  input  logic                  dump_req,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [31:0]           cycle_count,
  output logic                  heartbeat,
  output logic [15:0]           mismatch_count,
  output logic [ADDR_WIDTH-1:0] first_mismatch_addr,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] FirstAddr = ADDR_WIDTH'(1);
  localparam logic [31:0] MaxCount = 32'(MAX_CYCLES);
  localparam logic [31:0] HbLast = (HEARTBEAT > 0) ? 32'(HEARTBEAT - 1) : 32'd0;

  typedef enum logic [1:0] {StRun, StDump, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [ADDR_WIDTH-1:0] scan_q, scan_d;
  logic [31:0]           cycle_q, cycle_d;
  logic [31:0]           hb_cnt_q, hb_cnt_d;
  logic                  heartbeat_q, heartbeat_d;
  logic [15:0]           mis_cnt_q, mis_cnt_d;
  logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
  logic                  seen_q, seen_d;

  logic                  run, wr_hit, go_dump, entry_nz, dump_adv;
  logic [DATA_WIDTH-1:0] exp_a, exp_b;
  logic                  mis_a, mis_b;
  logic [16:0]           mis_sum;

  assign run      = (state_q == StRun);
  assign wr_hit   = wr_en && (wr_addr != '0);
  assign cycle_d  = run ? cycle_q + 32'd1 : cycle_q;
  assign go_dump  = run && ((cycle_d == MaxCount) || dump_req);
  assign entry_nz = (shadow_q[scan_q] != '0);
  assign dump_adv = (state_q == StDump) && (!entry_nz || dump_ready);

  // Expected read values come from the shadow as it stood before this cycle's write.
  always_comb begin
    exp_a = shadow_q[rd_addr_a];
    exp_b = shadow_q[rd_addr_b];
`ifdef REGMON_BYPASS_EN
    if (wr_hit && (rd_addr_a == wr_addr)) exp_a = wr_data;
    if (wr_hit && (rd_addr_b == wr_addr)) exp_b = wr_data;
`endif
    mis_a = run && chk_en && (rd_data_a != exp_a);
    mis_b = run && chk_en && (rd_data_b != exp_b);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (go_dump) state_d = StDump;
      StDump:  if (dump_adv && (scan_q == LastAddr)) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    scan_d = scan_q;
    if (go_dump) begin
      scan_d = FirstAddr;
    end else if (dump_adv && (scan_q != LastAddr)) begin
      scan_d = scan_q + FirstAddr;
    end

    mis_sum   = {1'b0, mis_cnt_q} + 17'(mis_a) + 17'(mis_b);
    mis_cnt_d = mis_sum[16] ? 16'hFFFF : mis_sum[15:0];

    first_addr_d = first_addr_q;
    seen_d       = seen_q;
    if (!seen_q && (mis_a || mis_b)) begin
      first_addr_d = mis_a ? rd_addr_a : rd_addr_b;
      seen_d       = 1'b1;
    end

    // The pulse is suppressed when the same edge leaves RUN.
    hb_cnt_d    = hb_cnt_q;
    heartbeat_d = 1'b0;
    if (run && (HEARTBEAT != 0)) begin
      if (hb_cnt_q == HbLast) begin
        hb_cnt_d    = '0;
        heartbeat_d = !go_dump;
      end else begin
        hb_cnt_d = hb_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StRun;
      scan_q       <= FirstAddr;
      cycle_q      <= '0;
      hb_cnt_q     <= '0;
      heartbeat_q  <= 1'b0;
      mis_cnt_q    <= '0;
      first_addr_q <= '0;
      seen_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      cycle_q      <= cycle_d;
      hb_cnt_q     <= hb_cnt_d;
      heartbeat_q  <= heartbeat_d;
      mis_cnt_q    <= mis_cnt_d;
      first_addr_q <= first_addr_d;
      seen_q       <= seen_d;
      if (run && wr_hit) shadow_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    dump_valid = (state_q == StDump) && entry_nz;
    dump_addr  = dump_valid ? scan_q : '0;
    dump_data  = dump_valid ? shadow_q[scan_q] : '0;
  end

  assign cycle_count         = cycle_q;
  assign heartbeat           = heartbeat_q;
  assign mismatch_count      = mis_cnt_q;
  assign first_mismatch_addr = first_addr_q;
  assign done                = (state_q == StDone);

endmodule

// File: tb/tb_regfile_monitor.sv
// Directed self-checking bench for regfile_monitor (default parameters, 32 x 32-bit shadow).
// Expectations for the same-cycle write/read case follow REGMON_BYPASS_EN when defined.
module tb_regfile_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        chk_en, dump_req, dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic [31:0] cycle_count;
  logic        heartbeat;
  logic [15:0] mismatch_count;
  logic [4:0]  first_mismatch_addr;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_monitor dut (
    .clock               (clock),
    .reset               (reset),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .rd_addr_a           (rd_addr_a),
    .rd_addr_b           (rd_addr_b),
    .rd_data_a           (rd_data_a),
    .rd_data_b           (rd_data_b),
    .chk_en              (chk_en),
    .dump_req            (dump_req),
    .dump_valid          (dump_valid),
    .dump_ready          (dump_ready),
    .dump_addr           (dump_addr),
    .dump_data           (dump_data),
    .cycle_count         (cycle_count),
    .heartbeat           (heartbeat),
    .mismatch_count      (mismatch_count),
    .first_mismatch_addr (first_mismatch_addr),
    .done                (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_addr_a = 0; rd_addr_b = 0; rd_data_a = 0; rd_data_b = 0;
    chk_en = 0; dump_req = 0; dump_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count);
    end
    n_tests++;
    if (mismatch_count !== 16'd0 || first_mismatch_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mismatch: got cnt=%0d first=%0d want 0/0", mismatch_count,
               first_mismatch_addr);
    end
    n_tests++;
    if (dump_valid !== 1'b0 || done !== 1'b0 || heartbeat !== 1'b0 || dump_addr !== 5'd0 ||
        dump_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b done=%b hb=%b addr=%0d data=%h want all 0",
               dump_valid, done, heartbeat, dump_addr, dump_data);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    write_reg(5'd5, 32'h0000_00AA);
    chk_en = 1; rd_addr_a = 5; rd_data_a = 32'hAA;
    tick();
    n_tests++;
    if (mismatch_count !== 16'd0) begin
      n_fail++; $display("FAIL read_match: got cnt=%0d want 0", mismatch_count);
    end
    n_tests++;
    if (cycle_count !== 32'd2) begin
      n_fail++; $display("FAIL run_cycle_count: got %0d want 2", cycle_count);
    end
    rd_data_a = 32'hAB;
    tick();
    n_tests++;
    if (mismatch_count !== 16'd1 || first_mismatch_addr !== 5'd5) begin
      n_fail++;
      $display("FAIL read_mismatch: got cnt=%0d first=%0d want 1/5", mismatch_count,
               first_mismatch_addr);
    end
    chk_en = 0;
    tick();
    n_tests++;
    if (mismatch_count !== 16'd1) begin
      n_fail++; $display("FAIL chk_disabled: got cnt=%0d want 1", mismatch_count);
    end
  endtask

  task automatic test_r0();
    int nvalid = 0;
    do_reset();
    write_reg(5'd0, 32'hFFFF_FFFF);
    chk_en = 1; rd_addr_a = 0; rd_data_a = 0; rd_addr_b = 0; rd_data_b = 0;
    tick();
    chk_en = 0;
    n_tests++;
    if (mismatch_count !== 16'd0) begin
      n_fail++; $display("FAIL r0_read: got cnt=%0d want 0", mismatch_count);
    end
    dump_req = 1;
    tick();
    dump_req = 0; dump_ready = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (dump_valid) nvalid++;
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || nvalid != 0) begin
      n_fail++; $display("FAIL r0_dump: got done=%b entries=%0d want 1/0", done, nvalid);
    end
    n_tests++;
    if (cycle_count !== 32'd3) begin
      n_fail++; $display("FAIL cycle_frozen: got %0d want 3", cycle_count);
    end
  endtask

  task automatic test_both_mismatch();
    do_reset();
    write_reg(5'd3, 32'h33);
    write_reg(5'd7, 32'h77);
    chk_en = 1;
    rd_addr_a = 3; rd_data_a = 32'h34;
    rd_addr_b = 7; rd_data_b = 32'h78;
    tick();
    n_tests++;
    if (mismatch_count !== 16'd2 || first_mismatch_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL both_mismatch: got cnt=%0d first=%0d want 2/3", mismatch_count,
               first_mismatch_addr);
    end
    rd_data_a = 32'h33;
    tick();
    n_tests++;
    if (mismatch_count !== 16'd3 || first_mismatch_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL b_only_mismatch: got cnt=%0d first=%0d want 3/3", mismatch_count,
               first_mismatch_addr);
    end
    chk_en = 0;
  endtask

  task automatic test_heartbeat();
    int pulses = 0;
    logic [31:0] hb_at [2];
    hb_at[0] = 0; hb_at[1] = 0;
    do_reset();
    dump_ready = 1;
    for (int i = 0; i < 340; i++) begin
      tick();
      if (heartbeat) begin
        if (pulses < 2) hb_at[pulses] = cycle_count;
        pulses++;
      end
    end
    n_tests++;
    if (pulses != 2 || hb_at[0] !== 32'd100 || hb_at[1] !== 32'd200) begin
      n_fail++;
      $display("FAIL heartbeat: got pulses=%0d at %0d,%0d want 2 at 100,200", pulses,
               hb_at[0], hb_at[1]);
    end
    n_tests++;
    if (cycle_count !== 32'd300 || done !== 1'b1) begin
      n_fail++; $display("FAIL auto_dump: got cycles=%0d done=%b want 300/1", cycle_count, done);
    end
  endtask

  task automatic test_dump_handshake();
    int waited = 0;
    do_reset();
    write_reg(5'd2, 32'h11);
    write_reg(5'd9, 32'h22);
    dump_req = 1;
    tick();
    dump_req = 0; dump_ready = 0;
    n_tests++;
    if (dump_valid !== 1'b0 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      n_fail++;
      $display("FAIL dump_skip_r1: got valid=%b addr=%0d data=%h want 0/0/0", dump_valid,
               dump_addr, dump_data);
    end
    tick();
    // Writes and checks during DUMP must be ignored.
    wr_en = 1; wr_addr = 2; wr_data = 32'h99;
    chk_en = 1; rd_addr_a = 2; rd_data_a = 32'h55;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dump_ready = 1;
      n_tests++;
      if (dump_valid !== 1'b1 || dump_addr !== 5'd2 || dump_data !== 32'h11) begin
        n_fail++;
        $display("FAIL dump_hold_%0d: got valid=%b addr=%0d data=%h want 1/2/11", i,
                 dump_valid, dump_addr, dump_data);
      end
      tick();
    end
    idle_inputs();
    dump_ready = 1;
    while (!dump_valid && waited < 10) begin
      tick();
      waited++;
    end
    n_tests++;
    if (dump_valid !== 1'b1 || dump_addr !== 5'd9 || dump_data !== 32'h22 || waited != 6) begin
      n_fail++;
      $display("FAIL dump_r9: got valid=%b addr=%0d data=%h after %0d want 1/9/22 after 6",
               dump_valid, dump_addr, dump_data, waited);
    end
    n_tests++;
    if (mismatch_count !== 16'd0) begin
      n_fail++; $display("FAIL dump_chk_ignored: got cnt=%0d want 0", mismatch_count);
    end
    for (int i = 0; i < 30 && !done; i++) tick();
    n_tests++;
    if (done !== 1'b1 || dump_valid !== 1'b0) begin
      n_fail++; $display("FAIL dump_done: got done=%b valid=%b want 1/0", done, dump_valid);
    end
    tick();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL done_held: got %b want 1", done);
    end
  endtask

  task automatic test_reset_mid_dump();
    do_reset();
    write_reg(5'd2, 32'h11);
    dump_req = 1;
    tick();
    dump_req = 0;
    tick();
    n_tests++;
    if (dump_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_dump_valid: got %b want 1", dump_valid);
    end
    reset = 1;
    tick();
    reset = 0;
    n_tests++;
    if (dump_valid !== 1'b0 || cycle_count !== 32'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_dump_reset: got valid=%b cycles=%0d done=%b want 0/0/0", dump_valid,
               cycle_count, done);
    end
    chk_en = 1; rd_addr_a = 2; rd_data_a = 0;
    tick();
    chk_en = 0;
    n_tests++;
    if (mismatch_count !== 16'd0) begin
      n_fail++; $display("FAIL shadow_cleared: got cnt=%0d want 0", mismatch_count);
    end
  endtask

  task automatic test_same_cycle();
    logic [15:0] exp_cnt;
    logic [4:0]  exp_first;
`ifdef REGMON_BYPASS_EN
    exp_cnt = 16'd0; exp_first = 5'd0;
`else
    exp_cnt = 16'd1; exp_first = 5'd4;
`endif
    do_reset();
    wr_en = 1; wr_addr = 4; wr_data = 32'h5;
    chk_en = 1; rd_addr_a = 4; rd_data_a = 32'h5;
    tick();
    idle_inputs();
    n_tests++;
    if (mismatch_count !== exp_cnt || first_mismatch_addr !== exp_first) begin
      n_fail++;
      $display("FAIL same_cycle_rw: got cnt=%0d first=%0d want %0d/%0d", mismatch_count,
               first_mismatch_addr, exp_cnt, exp_first);
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_r0();
    test_both_mismatch();
    test_heartbeat();
    test_dump_handshake();
    test_reset_mid_dump();
    test_same_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_monitor.md
REGFILE_MONITOR -- requirements
Module: regfile_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of a register value.
REQ-002 SHALL have parameter NUM_REGS, default 32, number of shadowed registers; ADDR_WIDTH = clog2(NUM_REGS).
REQ-003 SHALL have parameter MAX_CYCLES, default 300, number of RUN cycles before automatic dump.
REQ-004 SHALL have parameter HEARTBEAT, default 100, heartbeat period in cycles; 0 disables heartbeat.
REQ-005 SHALL have ports: clock in 1, sole clock; reset in 1, synchronous active-high reset.
REQ-006 SHALL have ports: wr_en in 1, regfile write enable; wr_addr in ADDR_WIDTH; wr_data in DATA_WIDTH.
REQ-007 SHALL have ports: rd_addr_a, rd_addr_b in ADDR_WIDTH; rd_data_a, rd_data_b in DATA_WIDTH; chk_en in 1, qualify read check.
REQ-008 SHALL have ports: dump_req in 1, force dump; dump_valid out 1; dump_ready in 1; dump_addr out ADDR_WIDTH; dump_data out DATA_WIDTH.
REQ-009 SHALL have ports: cycle_count out 32; heartbeat out 1, one-cycle pulse; mismatch_count out 16; first_mismatch_addr out ADDR_WIDTH; done out 1.

Function
REQ-010 SHALL implement states RUN, DUMP, DONE; RUN after reset.
REQ-011 SHALL in RUN, when wr_en=1 and wr_addr!=0, store wr_data into shadow[wr_addr] at clock edge; writes to address 0 ignored; shadow[0] always reads 0.
REQ-012 SHALL in RUN with chk_en=1 compare rd_data_a against shadow[rd_addr_a] and rd_data_b against shadow[rd_addr_b] in the same cycle, using pre-write shadow contents.
REQ-013 SHALL increment mismatch_count by the number of mismatching ports (0, 1 or 2) per cycle, saturating at 16'hFFFF.
REQ-014 SHALL capture first_mismatch_addr on the first mismatch after reset only; port A wins if both ports mismatch in that cycle.
REQ-015 SHALL increment cycle_count by 1 on every RUN cycle; cycle_count frozen in DUMP and DONE.
REQ-016 SHALL pulse heartbeat for one cycle in RUN whenever the post-increment cycle_count is a nonzero multiple of HEARTBEAT (HEARTBEAT>0).
REQ-017 SHALL transition RUN->DUMP at the edge where cycle_count reaches MAX_CYCLES or dump_req=1, whichever first; both in the same cycle cause one transition.
REQ-018 SHALL in DUMP scan addresses 1..NUM_REGS-1 ascending, one address per cycle when entry is zero (skipped, dump_valid=0).
REQ-019 SHALL for a nonzero entry assert dump_valid with dump_addr/dump_data stable until the cycle dump_ready=1; advance to next address after that handshake.
REQ-020 SHALL ignore wr_en, chk_en and dump_req in DUMP and DONE; shadow frozen.
REQ-021 SHALL transition DUMP->DONE after address NUM_REGS-1 is skipped or handshaken; done=1 held in DONE until reset.
REQ-022 SHALL drive dump_addr/dump_data to 0 whenever dump_valid=0.

Reset
REQ-023 SHALL on reset=1 at a clock edge clear all shadow entries, cycle_count, mismatch_count, first_mismatch_addr, heartbeat, dump_valid, done, and enter RUN.
REQ-024 SHALL honour reset mid-DUMP, aborting the scan with dump_valid=0 the next cycle; reset overrides all other inputs.

Configuration
REQ-025 SHALL with macro REGMON_BYPASS_EN defined compare a read port against wr_data when wr_en=1, wr_addr!=0 and read address equals wr_addr in the same cycle (write-through regfile).
REQ-026 SHALL without REGMON_BYPASS_EN compare against the pre-write shadow value per REQ-012 (write-at-edge regfile).

Verification
REQ-027 Write r5=0x0000_00AA, next cycle chk_en=1 rd_addr_a=5 rd_data_a=0xAA -> mismatch_count stays 0.
REQ-028 Write r0=0xFFFF_FFFF, then read r0 expecting 0 with rd_data_a=0 -> no mismatch; dump emits no r0 entry.
REQ-029 Both ports mismatch (rd_addr_a=3, rd_addr_b=7) in one cycle -> mismatch_count +2, first_mismatch_addr=3.
REQ-030 MAX_CYCLES=300, HEARTBEAT=100, no dump_req -> heartbeat pulses at cycle_count 100, 200; DUMP entered with cycle_count=300.
REQ-031 Writes r2=0x11, r9=0x22, dump_req=1, dump_ready low 3 cycles then high -> dump_valid held with addr 2 data 0x11 for 4 cycles, then addr 9 data 0x22, then done=1.
REQ-032 Write and read r4 same cycle, wr_data=0x5, rd_data_a=0x5, r4 previously 0 -> mismatch only without REGMON_BYPASS_EN.
